// File: rtl/perceptron.sv
// perceptron: trainable single neuron, step activation, perceptron-rule backward pass
module perceptron #(
  parameter int ARGW = 8,
  parameter int ARGN = 2,
  parameter int RESW = 8,
  parameter int ERRW = 16,
  parameter int WGTW = 16,
  parameter int FBKN = ARGN,
  parameter int FBKW = ERRW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 arg_valid,
  output logic                 arg_ready,
  input  logic [ARGN*ARGW-1:0] arg_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RESW-1:0]      res_data,
  input  logic                 err_valid,
  output logic                 err_ready,
  input  logic [ERRW-1:0]      err_data,
  output logic                 fbk_valid,
  input  logic                 fbk_ready,
  output logic [FBKN*FBKW-1:0] fbk_data
);
  localparam int IW = $clog2(ARGN + 2);
  localparam int AW = WGTW + ARGW + $clog2(ARGN + 1) + 1;
  localparam int PW = ERRW + WGTW;
  localparam int UW = (WGTW > ERRW + ARGW + 1 ? WGTW : ERRW + ARGW + 1) + 1;
  localparam logic signed [PW-1:0] FMAX = {{(PW-FBKW+1){1'b0}}, {(FBKW-1){1'b1}}};
  localparam logic signed [PW-1:0] FMIN = ~FMAX;
  localparam logic signed [UW-1:0] WMAX = {{(UW-WGTW+1){1'b0}}, {(WGTW-1){1'b1}}};
  localparam logic signed [UW-1:0] WMIN = ~WMAX;

  typedef enum logic [2:0] {IDLE, FWD, RES, BWD, FBK} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx;
  logic [ARGW-1:0]        args [ARGN];
  logic signed [WGTW-1:0] w [ARGN+1];
  logic signed [AW-1:0]   acc, prod;
  logic signed [ERRW-1:0] err;
  logic                   learn;
  logic signed [WGTW-1:0] wsel, w_sat;
  logic [ARGW-1:0]        asel;
  logic signed [PW-1:0]   pf, pfs;
  logic signed [UW-1:0]   pu, sum;
  logic signed [FBKW-1:0] fbk_sat;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    arg_ready = state == IDLE;
    err_ready = state == IDLE;
    res_valid = state == RES;
    fbk_valid = state == FBK;
    case (state)
      IDLE:    state_nxt = err_valid ? BWD : (arg_valid ? FWD : IDLE);
      FWD:     state_nxt = idx == IW'(ARGN + 1) ? RES : FWD;
      RES:     state_nxt = res_ready ? IDLE : RES;
      BWD:     state_nxt = idx == IW'(ARGN) ? FBK : BWD;
      FBK:     state_nxt = fbk_ready ? IDLE : FBK;
      default: state_nxt = IDLE;
    endcase
  end

  // asel defaults to all-ones, which is the bias input at idx == ARGN
  always_comb begin
    wsel = '0;
    asel = '1;
    for (int i = 0; i < ARGN; i++)
      if (idx == IW'(i)) begin
        wsel = w[i];
        asel = args[i];
      end
    if (idx == IW'(ARGN)) wsel = w[ARGN];
    prod = AW'(wsel) * AW'($signed({1'b0, asel}));
    pf = PW'(err) * PW'(wsel);
    pfs = pf >>> 8;
    pu = UW'(err) * UW'($signed({1'b0, asel}));
    sum = UW'(wsel) + (pu >>> 8);
    fbk_sat = pfs > FMAX ? FMAX[FBKW-1:0] : (pfs < FMIN ? FMIN[FBKW-1:0] : pfs[FBKW-1:0]);
    w_sat = sum > WMAX ? WMAX[WGTW-1:0] : (sum < WMIN ? WMIN[WGTW-1:0] : sum[WGTW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      acc <= '0;
      err <= '0;
      learn <= 1'b0;
      res_data <= '0;
      fbk_data <= '0;
      for (int i = 0; i < ARGN; i++) args[i] <= '0;
      for (int i = 0; i <= ARGN; i++) w[i] <= '0;
    end else begin
      idx <= (state == FWD || state == BWD) ? idx + 1'b1 : '0;
      acc <= state == FWD ? acc + prod : '0;
      if (state == IDLE && err_valid) begin
        err <= err_data;
        learn <= en;
      end
      if (state == IDLE && !err_valid && arg_valid)
        for (int i = 0; i < ARGN; i++) args[i] <= arg_data[i*ARGW +: ARGW];
      if (state == FWD && idx == IW'(ARGN + 1)) res_data <= (!acc[AW-1] && |acc) ? '1 : '0;
      if (state == BWD) begin
        for (int i = 0; i < FBKN; i++)
          if (idx == IW'(i)) fbk_data[i*FBKW +: FBKW] <= fbk_sat;
        for (int i = 0; i <= ARGN; i++)
          if (idx == IW'(i) && learn) w[i] <= w_sat;
      end
    end
endmodule

// File: tb/tb_perceptron.sv
// tb_perceptron: directed and randomized checks of perceptron against an arithmetic model
module tb_perceptron;
  localparam int ARGW = 8, ARGN = 2, RESW = 8, ERRW = 16, WGTW = 16, FBKN = ARGN, FBKW = ERRW;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic arg_valid = 1'b0, res_ready = 1'b0, err_valid = 1'b0, fbk_ready = 1'b0;
  logic [ARGN*ARGW-1:0] arg_data = '0;
  logic [ERRW-1:0] err_data = '0;
  logic arg_ready, res_valid, err_ready, fbk_valid;
  logic [RESW-1:0] res_data;
  logic [FBKN*FBKW-1:0] fbk_data;

  int checks = 0, errors = 0;
  longint wm [ARGN+1];
  longint am [ARGN+1];

  perceptron #(.ARGW(ARGW), .ARGN(ARGN), .RESW(RESW), .ERRW(ERRW), .WGTW(WGTW),
               .FBKN(FBKN), .FBKW(FBKW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .arg_valid(arg_valid), .arg_ready(arg_ready), .arg_data(arg_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
    .fbk_valid(fbk_valid), .fbk_ready(fbk_ready), .fbk_data(fbk_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int b);
    longint hi = (64'sd1 <<< (b - 1)) - 1;
    return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
  endfunction

  task automatic model_fwd(input int a0, input int a1, output int res);
    longint acc = 0;
    am[0] = a0;
    am[1] = a1;
    am[ARGN] = 255;
    for (int i = 0; i <= ARGN; i++) acc += wm[i] * am[i];
    res = acc > 0 ? 255 : 0;
  endtask

  task automatic model_bwd(input longint e, input bit lrn, output longint f [FBKN]);
    for (int i = 0; i < FBKN; i++) f[i] = sat((e * wm[i]) >>> 8, FBKW);
    if (lrn)
      for (int i = 0; i <= ARGN; i++) wm[i] = sat(wm[i] + ((e * am[i]) >>> 8), WGTW);
  endtask

  task automatic fwd(input int a0, input int a1, input int hold, output int res);
    int n, exp_res;
    arg_data = {8'(a1), 8'(a0)};
    arg_valid = 1'b1;
    n = 0;
    while (!arg_ready && n < 50) begin tick(); n++; end
    chk("fwd_accept", arg_ready, 1);
    tick();
    arg_valid = 1'b0;
    model_fwd(a0, a1, exp_res);
    n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    chk("fwd_latency", n, ARGN + 2);
    chk("res_data", res_data, exp_res);
    res = res_data;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("res_hold_valid", res_valid, 1);
      chk("res_hold_data", res_data, exp_res);
      chk("res_hold_arg_ready", arg_ready, 0);
      chk("res_hold_err_ready", err_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_release", res_valid, 0);
  endtask

  task automatic bwd(input int e, input bit lrn, input int hold);
    int n;
    longint f [FBKN];
    err_data = 16'(e);
    en = lrn;
    err_valid = 1'b1;
    n = 0;
    while (!err_ready && n < 50) begin tick(); n++; end
    chk("bwd_accept", err_ready, 1);
    tick();
    err_valid = 1'b0;
    en = ~lrn;
    model_bwd(e, lrn, f);
    n = 0;
    while (!fbk_valid && n < 50) begin tick(); n++; end
    chk("bwd_latency", n, ARGN + 1);
    for (int i = 0; i < FBKN; i++) chk("fbk_data", $signed(fbk_data[i*FBKW +: FBKW]), f[i]);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("fbk_hold_valid", fbk_valid, 1);
      for (int i = 0; i < FBKN; i++) chk("fbk_hold_data", $signed(fbk_data[i*FBKW +: FBKW]), f[i]);
      chk("fbk_hold_arg_ready", arg_ready, 0);
      chk("fbk_hold_err_ready", err_ready, 0);
    end
    fbk_ready = 1'b1;
    tick();
    fbk_ready = 1'b0;
    chk("fbk_release", fbk_valid, 0);
  endtask

  initial begin
    int r, r1, r2, n, exp_res;
    int tgt [4] = '{0, 0, 0, 255};
    int pa [4] = '{0, 0, 255, 255};
    int pb [4] = '{0, 255, 0, 255};
    longint f [FBKN];
    for (int i = 0; i <= ARGN; i++) begin wm[i] = 0; am[i] = 0; end
    am[ARGN] = 255;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_fbk_valid", fbk_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_arg_ready", arg_ready, 1);
    chk("rst_err_ready", err_ready, 1);
    chk("rst_res_data", res_data, 0);
    chk("rst_fbk_data", fbk_data, 0);

    fwd(0, 0, 0, r);
    chk("zero_w_res00", r, 0);
    fwd(255, 255, 0, r);
    chk("zero_w_resff", r, 0);
    bwd(255, 1'b1, 0);
    chk("first_fbk0", $signed(fbk_data[FBKW-1:0]), 0);
    chk("w_after_first", wm[0] + wm[1] + wm[2], 3 * 254);
    fwd(0, 0, 0, r);
    chk("bias_learned", r, 255);

    for (int ep = 0; ep < 10; ep++)
      for (int p = 0; p < 4; p++) begin
        fwd(pa[p], pb[p], 0, r);
        bwd(tgt[p] - r, 1'b1, 0);
      end
    for (int p = 0; p < 4; p++) begin
      fwd(pa[p], pb[p], 0, r);
      chk("and_err", tgt[p] - r, 0);
      bwd(tgt[p] - r, 1'b0, 0);
    end

    fwd(255, 255, 0, r1);
    bwd(255, 1'b0, 0);
    fwd(255, 255, 0, r2);
    chk("en0_res_unchanged", r2, r1);

    fwd(8'h80, 8'h40, 5, r);
    bwd(100, 1'b0, 5);

    arg_data = {8'h11, 8'hEE};
    arg_valid = 1'b1;
    err_data = 16'(-100);
    en = 1'b0;
    err_valid = 1'b1;
    chk("sim_err_ready", err_ready, 1);
    tick();
    err_valid = 1'b0;
    model_bwd(-100, 1'b0, f);
    n = 0;
    while (!fbk_valid && n < 50) begin
      chk("sim_no_res", res_valid, 0);
      tick();
      n++;
    end
    chk("sim_fbk_valid", fbk_valid, 1);
    for (int i = 0; i < FBKN; i++) chk("sim_fbk", $signed(fbk_data[i*FBKW +: FBKW]), f[i]);
    chk("sim_arg_blocked", arg_ready, 0);
    fbk_ready = 1'b1;
    tick();
    fbk_ready = 1'b0;
    chk("sim_arg_after_fbk", arg_ready, 1);
    tick();
    arg_valid = 1'b0;
    model_fwd(8'hEE, 8'h11, exp_res);
    n = 0;
    while (!res_valid && n < 50) begin tick(); n++; end
    chk("sim_res_latency", n, ARGN + 2);
    chk("sim_res", res_data, exp_res);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    for (int k = 0; k < 30; k++) begin
      int e;
      fwd($urandom_range(0, 255), $urandom_range(0, 255), 0, r);
      case ($urandom_range(0, 3))
        0: e = 255 - r;
        1: e = -r;
        2: e = $urandom_range(0, 65535) - 32768;
        default: e = $urandom_range(0, 1023) - 512;
      endcase
      bwd(e, 1'($urandom_range(0, 1)), 0);
    end

    arg_data = {8'hFF, 8'hFF};
    arg_valid = 1'b1;
    tick();
    arg_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_fbk_valid", fbk_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_arg_ready", arg_ready, 1);
    chk("midrst_res_data", res_data, 0);
    for (int i = 0; i <= ARGN; i++) begin wm[i] = 0; am[i] = 0; end
    am[ARGN] = 255;
    bwd(255, 1'b0, 0);
    fwd(0, 0, 0, r);
    chk("midrst_w_zero", r, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
